alu_issue_decoder: RTL and testbench
====================================

Name: alu_issue_decoder

Overview:
- Decode-side producer for the 32-bit RISC-V integer ALU.
- Accepts one instruction per handshake (instruction word, PC, register-file read data).
- Decodes OP, OP-IMM, LUI and AUIPC into the ALU's 4-bit operation code plus operands A/B.
- Registers the result into a one-deep ID/EX stage with valid/ready backpressure, flush, and an illegal-instruction counter.

Parameters:
CNT_W, 8, width of saturating illegal-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
flush  input  1  drop held/incoming instruction
in_valid  input  1  upstream instruction valid
in_ready  output  1  decoder can accept this cycle
instr  input  32  instruction word
pc  input  32  instruction address
rs1_data  input  32  register-file read port 1
rs2_data  input  32  register-file read port 2
out_valid  output  1  decoded bundle valid
out_ready  input  1  execute stage accepts bundle
op_a  output  32  ALU operand A
op_b  output  32  ALU operand B
alu_control  output  4  ALU operation code
rd_addr  output  5  destination register
rd_we  output  1  writeback enable
illegal  output  1  bundle is an illegal/unsupported instruction
illegal_count  output  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous, active-high.
- Reset: out_valid=0, op_a=0, op_b=0, alu_control=0000, rd_addr=0, rd_we=0, illegal=0, illegal_count=0. Reset mid-stall discards the held bundle.
- Op codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready), combinational.
  - Accept when in_valid && in_ready; decoded bundle appears on outputs the next cycle with out_valid=1 (latency 1).
  - Bundle consumed when out_valid && out_ready.
  - Consume and accept in the same cycle: new bundle replaces old, out_valid stays 1.
  - Consume without accept: out_valid=0 next cycle.
  - While out_valid && !out_ready, all outputs hold stable.
- Flush: has priority over everything except rst. out_valid=0 next cycle; any concurrent in_valid is dropped; illegal_count not incremented for a dropped instruction.
- Decode, opcode 0110011 (OP):
  - A=rs1_data, B=rs2_data.
  - With funct7=0000000, funct3 selects: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3=000 gives SUB, funct3=101 gives SRA.
  - Any other funct7/funct3 combination is illegal.
- Decode, opcode 0010011 (OP-IMM):
  - A=rs1_data, B=sign-extended instr[31:20].
  - funct3 selects: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - Shift forms: funct3=001 with instr[31:25]=0000000 gives SLL. funct3=101 gives SRL when instr[31:25]=0000000 and SRA when 0100000.
  - For shifts, B = zero-extended instr[24:20].
  - Any other shift encoding is illegal.
- Decode, opcode 0110111 (LUI): A=0, B={instr[31:12],12'b0}, ADD.
- Decode, opcode 0010111 (AUIPC): A=pc, B={instr[31:12],12'b0}, ADD.
- Any other opcode is illegal.
- Illegal bundle: still issued with out_valid=1, illegal=1, alu_control=0000, op_a=0, op_b=0, rd_we=0.
- rd_addr = instr[11:7]. rd_we = !illegal && rd_addr!=0.
- illegal_count: +1 on each accepted illegal instruction; saturates at all-ones; cleared only by rst.

Test Plan:
1. add x3,x1,x2:
   - Stimulus: instr=0x002081B3, rs1_data=5, rs2_data=7, out_ready=1.
   - Response: next cycle out_valid=1, alu_control=0000, op_a=5, op_b=7, rd_addr=3, rd_we=1, illegal=0.
2. srai x5,x6,4 and addi x1,x0,-1:
   - srai: instr=0x40435293, rs1_data=0x80000000 gives alu_control=0111, op_b=4, rd_addr=5.
   - addi: instr=0xFFF00093 gives alu_control=0000, op_b=0xFFFFFFFF, rd_we=1.
3. Backpressure:
   - Stimulus: two back-to-back valid instructions, out_ready=0 for 3 cycles after the first is issued.
   - Response: in_ready=0 and outputs stable for those 3 cycles. The cycle out_ready=1, in_ready=1 and the second instruction is accepted. Second bundle appears the next cycle; no duplication or loss.
4. Illegal and x0 destination:
   - ecall 0x00000073: illegal=1, rd_we=0, illegal_count=1.
   - mul 0x02208133: illegal=1, illegal_count=2.
   - add x0,x1,x2 (0x00208033): rd_we=0, illegal=0.
   - 2^CNT_W+5 illegal instructions leave illegal_count=all-ones.
5. Flush:
   - Stimulus: out_valid=1, out_ready=0, flush=1 together with in_valid=1 carrying an illegal instruction.
   - Response: in_ready=0, out_valid=0 next cycle, illegal_count unchanged. The following instruction issues normally.
6. Reset mid-operation:
   - Stimulus: rst=1 for one cycle while a bundle is stalled.
   - Response: next cycle all outputs are at reset values, illegal_count=0, in_ready=1 once rst is low.

Source files
------------

// File: rtl/alu_issue_decoder.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode into a one-deep ID/EX register; latency 1 cycle.
// Backpressure: in_ready drops while a held bundle is stalled or flush is asserted.
module alu_issue_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      op_a,
  output logic [31:0]      op_b,
  output logic [3:0]       alu_control,
  output logic [4:0]       rd_addr,
  output logic             rd_we,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_control;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;
  } bundle_t;

  bundle_t          dec_dat;
  bundle_t          stage_dat;
  logic             stage_vld;
  logic [CNT_W-1:0] ill_cnt;
  logic             accept;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  assign in_ready = !flush && (!stage_vld || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_dat             = '0;
    dec_dat.alu_control = ALU_ADD;
    dec_dat.rd_addr     = instr[11:7];
    unique case (opcode)
      OPC_OP: begin
        dec_dat.op_a = rs1_data;
        dec_dat.op_b = rs2_data;
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            3'b000: dec_dat.alu_control = ALU_ADD;
            3'b001: dec_dat.alu_control = ALU_SLL;
            3'b010: dec_dat.alu_control = ALU_SLT;
            3'b011: dec_dat.alu_control = ALU_SLTU;
            3'b100: dec_dat.alu_control = ALU_XOR;
            3'b101: dec_dat.alu_control = ALU_SRL;
            3'b110: dec_dat.alu_control = ALU_OR;
            default: dec_dat.alu_control = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_dat.alu_control = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_dat.alu_control = ALU_SRA;
        end else begin
          dec_dat.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_dat.op_a = rs1_data;
        dec_dat.op_b = imm_i;
        unique case (funct3)
          3'b000: dec_dat.alu_control = ALU_ADD;
          3'b010: dec_dat.alu_control = ALU_SLT;
          3'b011: dec_dat.alu_control = ALU_SLTU;
          3'b100: dec_dat.alu_control = ALU_XOR;
          3'b110: dec_dat.alu_control = ALU_OR;
          3'b111: dec_dat.alu_control = ALU_AND;
          3'b001: begin
            dec_dat.op_b        = shamt;
            dec_dat.alu_control = ALU_SLL;
            dec_dat.illegal     = (funct7 != F7_BASE);
          end
          default: begin
            dec_dat.op_b        = shamt;
            dec_dat.alu_control = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_dat.illegal     = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        dec_dat.op_b = imm_u;
      end
      OPC_AUIPC: begin
        dec_dat.op_a = pc;
        dec_dat.op_b = imm_u;
      end
      default: dec_dat.illegal = 1'b1;
    endcase
    // Illegal bundles still issue, but with neutral operands so EX does nothing harmful.
    if (dec_dat.illegal) begin
      dec_dat.op_a        = '0;
      dec_dat.op_b        = '0;
      dec_dat.alu_control = ALU_ADD;
    end
    dec_dat.rd_we = !dec_dat.illegal && (dec_dat.rd_addr != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_vld <= 1'b0;
      stage_dat <= '0;
      ill_cnt   <= '0;
    end else if (flush) begin
      stage_vld <= 1'b0;
    end else if (accept) begin
      stage_vld <= 1'b1;
      stage_dat <= dec_dat;
      if (dec_dat.illegal && (ill_cnt != {CNT_W{1'b1}})) begin
        ill_cnt <= ill_cnt + 1'b1;
      end
    end else if (out_ready) begin
      stage_vld <= 1'b0;
    end
  end

  assign out_valid     = stage_vld;
  assign op_a          = stage_dat.op_a;
  assign op_b          = stage_dat.op_b;
  assign alu_control   = stage_dat.alu_control;
  assign rd_addr       = stage_dat.rd_addr;
  assign rd_we         = stage_dat.rd_we;
  assign illegal       = stage_dat.illegal;
  assign illegal_count = ill_cnt;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed plus randomized check of alu_issue_decoder against a queue-based reference model.
module tb_alu_issue_decoder;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instr = '0;
  logic [31:0]      pc = '0;
  logic [31:0]      rs1_data = '0;
  logic [31:0]      rs2_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [3:0]       alu_control;
  logic [4:0]       rd_addr;
  logic             rd_we;
  logic             illegal;
  logic [CNT_W-1:0] illegal_count;

  alu_issue_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .alu_control(alu_control),
    .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t m_q[$];
  int   m_cnt = 0;

  // funct3 -> code for the register/immediate forms that share a table
  int f3_tbl[8] = '{0, 5, 8, 9, 4, 6, 3, 2};

  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int opc, f3, f7;
    logic [31:0] imm_i, imm_u;
    opc   = int'(ins[6:0]);
    f3    = int'(ins[14:12]);
    f7    = int'(ins[31:25]);
    imm_i = 32'(ins[31:20]);
    if (ins[31]) imm_i = imm_i - 32'd4096;
    imm_u = ins & 32'hFFFF_F000;
    e     = '0;
    e.rd  = ins[11:7];
    if (opc == 'h33) begin
      e.a = r1; e.b = r2;
      if (f7 == 0) e.ctrl = 4'(f3_tbl[f3]);
      else if (f7 == 32 && f3 == 0) e.ctrl = 4'd1;
      else if (f7 == 32 && f3 == 5) e.ctrl = 4'd7;
      else e.ill = 1'b1;
    end else if (opc == 'h13) begin
      e.a = r1;
      if (f3 == 1 || f3 == 5) begin
        e.b = 32'(ins[24:20]);
        if (f7 == 0) e.ctrl = 4'(f3_tbl[f3]);
        else if (f7 == 32 && f3 == 5) e.ctrl = 4'd7;
        else e.ill = 1'b1;
      end else begin
        e.b = imm_i; e.ctrl = 4'(f3_tbl[f3]);
      end
    end else if (opc == 'h37) begin
      e.b = imm_u;
    end else if (opc == 'h17) begin
      e.a = p; e.b = imm_u;
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) begin
      e.a = '0; e.b = '0; e.ctrl = '0;
    end
    e.we = !e.ill && (e.rd != 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check in_ready, advance model and DUT, check outputs.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl, input logic rs);
    logic rdy_exp;
    exp_t e;
    in_valid = v; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
    out_ready = ordy; flush = fl; rst = rs;
    #1;
    rdy_exp = !fl && (m_q.size() == 0 || ordy);
    chk("in_ready", 32'(in_ready), 32'(rdy_exp));
    e = ref_dec(ins, p, r1, r2);
    @(posedge clk);
    if (rs) begin
      m_q.delete(); m_cnt = 0;
    end else if (fl) begin
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && ordy) void'(m_q.pop_front());
      if (v && rdy_exp) begin
        m_q.push_back(e);
        if (e.ill && m_cnt < CNT_MAX) m_cnt++;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("op_a", op_a, m_q[0].a);
      chk("op_b", op_b, m_q[0].b);
      chk("alu_control", 32'(alu_control), 32'(m_q[0].ctrl));
      chk("rd_addr", 32'(rd_addr), 32'(m_q[0].rd));
      chk("rd_we", 32'(rd_we), 32'(m_q[0].we));
      chk("illegal", 32'(illegal), 32'(m_q[0].ill));
    end
    chk("illegal_count", 32'(illegal_count), 32'(m_cnt));
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  opc, f7;
    int          sel;

    // Reset state
    cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_alu_control", 32'(alu_control), 32'd0);
    chk("rst_rd", 32'(rd_addr), 32'd0);
    chk("rst_rd_we", 32'(rd_we), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_count", 32'(illegal_count), 32'd0);

    // add x3,x1,x2
    cycle(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
    chk("add_vld", 32'(out_valid), 32'd1);
    chk("add_ctrl", 32'(alu_control), 32'h0);
    chk("add_a", op_a, 32'd5);
    chk("add_b", op_b, 32'd7);
    chk("add_rd", 32'(rd_addr), 32'd3);
    chk("add_we", 32'(rd_we), 32'd1);
    chk("add_ill", 32'(illegal), 32'd0);

    // srai x5,x6,4 ; addi x1,x0,-1
    cycle(1'b1, 32'h40435293, 32'h104, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("srai_ctrl", 32'(alu_control), 32'h7);
    chk("srai_b", op_b, 32'd4);
    chk("srai_rd", 32'(rd_addr), 32'd5);
    cycle(1'b1, 32'hFFF00093, 32'h108, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("addi_ctrl", 32'(alu_control), 32'h0);
    chk("addi_b", op_b, 32'hFFFF_FFFF);
    chk("addi_we", 32'(rd_we), 32'd1);

    // Backpressure: first add x3 issued, 3 stall cycles, then sub x6 accepted
    cycle(1'b1, 32'h002081B3, 32'h10C, 32'd11, 32'd22, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h40208333, 32'h110, 32'd50, 32'd8, 1'b0, 1'b0, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_a", op_a, 32'd11);
      chk("bp_hold_b", op_b, 32'd22);
    end
    cycle(1'b1, 32'h40208333, 32'h110, 32'd50, 32'd8, 1'b1, 1'b0, 1'b0);
    chk("bp_second_ctrl", 32'(alu_control), 32'h1);
    chk("bp_second_rd", 32'(rd_addr), 32'd6);
    cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Illegal and x0 destination
    cycle(1'b1, 32'h00000073, 32'h114, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
    chk("ecall_ill", 32'(illegal), 32'd1);
    chk("ecall_we", 32'(rd_we), 32'd0);
    chk("ecall_cnt", 32'(illegal_count), 32'd1);
    cycle(1'b1, 32'h02208133, 32'h118, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
    chk("mul_ill", 32'(illegal), 32'd1);
    chk("mul_cnt", 32'(illegal_count), 32'd2);
    cycle(1'b1, 32'h00208033, 32'h11C, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
    chk("x0_we", 32'(rd_we), 32'd0);
    chk("x0_ill", 32'(illegal), 32'd0);

    // Flush while stalled, with an illegal instruction offered
    cycle(1'b1, 32'h002081B3, 32'h120, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000073, 32'h124, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("flush_vld", 32'(out_valid), 32'd0);
    chk("flush_cnt", 32'(illegal_count), 32'd2);
    cycle(1'b1, 32'h002081B3, 32'h128, 32'd9, 32'd1, 1'b1, 1'b0, 1'b0);
    chk("post_flush_a", op_a, 32'd9);

    // Saturation
    for (int i = 0; i < (1 << CNT_W) + 5; i++)
      cycle(1'b1, 32'h00000073, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("sat_cnt", 32'(illegal_count), 32'(CNT_MAX));

    // Reset mid-stall
    cycle(1'b1, 32'h002081B3, 32'h12C, 32'd6, 32'd6, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst2_vld", 32'(out_valid), 32'd0);
    chk("rst2_cnt", 32'(illegal_count), 32'd0);
    chk("rst2_a", op_a, 32'd0);
    chk("rst2_ctrl", 32'(alu_control), 32'd0);
    cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4) opc = 7'h33;
      else if (sel < 7) opc = 7'h13;
      else if (sel == 7) opc = 7'h37;
      else if (sel == 8) opc = 7'h17;
      else opc = 7'($urandom);
      sel = int'($urandom_range(0, 3));
      f7 = (sel == 1) ? 7'h20 : (sel == 3) ? 7'($urandom) : 7'h00;
      ins = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
      cycle(1'($urandom_range(0, 3) != 0), ins, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
